// File: rtl/permutation_scheduler.sv
// Ascon-style permutation scheduler: accepts a 320-bit state and a round count,
// applies UNROLL rounds per cycle and hands the result over a valid/ready port.
module permutation_scheduler #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   nr,
  input  logic [319:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] state_out,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         st;
  logic [3:0]   cnt;
  logic [319:0] s_q;
  logic [319:0] chain [UNROLL+1];
  logic         nr_legal;
  logic         take;

  // One round: constant addition, bitsliced 5-bit S-box, per-lane linear diffusion.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] rnd);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    x2 = x2 ^ {56'd0, ~rnd, rnd};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
    x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
    x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
    x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
    x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
    return {x0, x1, x2, x3, x4};
  endfunction

  assign chain[0] = s_q;

  genvar k;
  generate
    for (k = 0; k < UNROLL; k++) begin : g_round
      assign chain[k+1] = ascon_round(chain[k], cnt + 4'(k));
    end
  endgenerate

  // UNROLL is a power of two, so the multiple-of test is a mask on the low bits.
  assign nr_legal  = (nr != 4'd0) && (nr <= 4'd12) && ((nr & 4'(UNROLL - 1)) == 4'd0);
  assign in_ready  = (st == IDLE) || ((st == DONE) && out_ready);
  assign take      = in_valid && in_ready;
  assign out_valid = (st == DONE);
  assign busy      = (st == RUN);
  assign state_out = s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      cnt <= '0;
      s_q <= '0;
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      case (st)
        RUN: begin
          s_q <= chain[UNROLL];
          cnt <= cnt + 4'(UNROLL);
          if (cnt + 4'(UNROLL) == 4'd12) st <= DONE;
        end
        default: begin
          if (in_ready) begin
            if (take && nr_legal) begin
              s_q <= state_in;
              cnt <= 4'd12 - nr;
              st  <= RUN;
            end else begin
              st  <= IDLE;
              err <= take;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_permutation_scheduler.sv
// Directed bench for permutation_scheduler: UNROLL=1 and UNROLL=4 instances checked
// against a table-driven S-box reference through an expected-result queue.
module tb_permutation_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_a, in_valid_b, out_ready;
  logic [3:0]   nr;
  logic [319:0] state_in;
  logic         in_ready_a, out_valid_a, busy_a, err_a;
  logic         in_ready_b, out_valid_b, busy_b, err_b;
  logic [319:0] state_out_a, state_out_b;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  logic [319:0] sb [$];
  bit           sel;

  always #5 clk = ~clk;

  permutation_scheduler #(.UNROLL(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .nr(nr),
    .state_in(state_in), .out_valid(out_valid_a), .out_ready(out_ready),
    .state_out(state_out_a), .busy(busy_a), .err(err_a)
  );

  permutation_scheduler #(.UNROLL(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .nr(nr),
    .state_in(state_in), .out_valid(out_valid_b), .out_ready(out_ready),
    .state_out(state_out_b), .busy(busy_b), .err(err_b)
  );

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [63:0] rot(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] golden(input logic [319:0] s, input int n);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  idx, o;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    for (int r = 12 - n; r < 12; r++) begin
      x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        idx = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o   = SBOX[idx];
        for (int i = 0; i < 5; i++) y[i][b] = o[4 - i];
      end
      x[0] = y[0] ^ rot(y[0], 19) ^ rot(y[0], 28);
      x[1] = y[1] ^ rot(y[1], 61) ^ rot(y[1], 39);
      x[2] = y[2] ^ rot(y[2], 1)  ^ rot(y[2], 6);
      x[3] = y[3] ^ rot(y[3], 10) ^ rot(y[3], 17);
      x[4] = y[4] ^ rot(y[4], 7)  ^ rot(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic g_ir();        return sel ? in_ready_b  : in_ready_a;  endfunction
  function automatic logic g_ov();        return sel ? out_valid_b : out_valid_a; endfunction
  function automatic logic g_busy();      return sel ? busy_b      : busy_a;      endfunction
  function automatic logic g_err();       return sel ? err_b       : err_a;       endfunction
  function automatic logic [319:0] g_so(); return sel ? state_out_b : state_out_a; endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_valid(input logic v);
    if (sel) in_valid_b = v; else in_valid_a = v;
  endtask

  // Leaves the caller at the first falling edge after the accepting clock edge.
  task automatic start_job(input int n, input logic [319:0] v, input bit push);
    int unsigned t = 0;
    while (!g_ir() && t < 20) begin @(negedge clk); t++; end
    chk("ready_before_job", 320'(g_ir()), 320'(1));
    drive_valid(1'b1);
    nr       = 4'(n);
    state_in = v;
    if (push) sb.push_back(golden(v, n));
    @(negedge clk);
    drive_valid(1'b0);
  endtask

  task automatic wait_done(input int exp_lat);
    int unsigned k = 1, bc = 0;
    while (!g_ov() && k < 40) begin
      bc += 32'(g_busy());
      @(negedge clk);
      k++;
    end
    chk("latency", 320'(k), 320'(exp_lat));
    chk("busy_cycles", 320'(bc), 320'(exp_lat - 1));
    if (sb.size() == 0) chk("scoreboard_empty", 320'(0), 320'(1));
    else chk("state_out", g_so(), sb.pop_front());
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_take", 320'(g_ov()), 320'(0));
  endtask

  task automatic illegal(input bit s, input int n);
    logic [319:0] prev;
    sel  = s;
    @(negedge clk);
    prev = g_so();
    drive_valid(1'b1);
    nr   = 4'(n);
    state_in = rnd320();
    @(negedge clk);
    drive_valid(1'b0);
    chk("err_pulse", 320'(g_err()), 320'(1));
    chk("err_stays_idle", 320'({g_busy(), g_ov(), g_ir()}), 320'(3'b001));
    chk("err_state_kept", g_so(), prev);
    @(negedge clk);
    chk("err_one_cycle", 320'(g_err()), 320'(0));
  endtask

  initial begin
    logic [319:0] first_res, u1_p12;
    int unsigned  seen;
    rst = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0; out_ready = 1'b0;
    nr = '0; state_in = '0; sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_regs", {g_ir(), g_ov(), g_busy(), g_err()}, 320'(4'b1000));
    chk("rst_state", g_so(), '0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_regs", {g_ir(), g_ov(), g_busy(), g_err()}, 320'(4'b1000));
    chk("post_rst_state", g_so(), '0);

    // UNROLL=1, pa on the zero state, then a held-off result
    start_job(12, '0, 1'b1);
    wait_done(13);
    first_res = g_so();
    u1_p12    = first_res;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 320'(g_ov()), 320'(1));
      chk("hold_state", g_so(), first_res);
    end

    // take the result and start a pb job on the same cycle
    out_ready  = 1'b1;
    in_valid_a = 1'b1;
    nr         = 4'd8;
    state_in   = rnd320();
    sb.push_back(golden(state_in, 8));
    @(negedge clk);
    out_ready  = 1'b0;
    in_valid_a = 1'b0;
    chk("b2b_run", 320'({g_busy(), g_ov()}), 320'(2'b10));
    wait_done(9);
    release_result();

    // single round, shortest legal job
    start_job(1, rnd320(), 1'b1);
    wait_done(2);
    release_result();

    // UNROLL=4
    sel = 1'b1;
    @(negedge clk);
    start_job(12, '0, 1'b1);
    wait_done(4);
    chk("unroll_match", g_so(), u1_p12);
    release_result();
    start_job(8, rnd320(), 1'b1);
    wait_done(3);
    release_result();

    illegal(1'b0, 0);
    illegal(1'b0, 13);
    illegal(1'b1, 6);

    // reset on the fifth RUN cycle of a pa job
    sel = 1'b0;
    @(negedge clk);
    start_job(12, rnd320(), 1'b0);
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 320'(g_busy()), 320'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_regs", {g_ir(), g_ov(), g_busy()}, 320'(3'b100));
    chk("mid_rst_state", g_so(), '0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen += 32'(g_ov());
    end
    chk("no_valid_after_rst", 320'(seen), 320'(0));
    chk("scoreboard_drained", 320'(sb.size()), 320'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/permutation_scheduler.md
PERMUTATION_SCHEDULER -- requirements
Module: permutation_scheduler

Interface
REQ-001 SHALL have parameter UNROLL, default 1: rounds applied per clock cycle; legal values 1, 2, 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the requester offers a permutation job.
REQ-005 SHALL have port in_ready, output, 1 bit: the scheduler can accept a job this cycle.
REQ-006 SHALL have port nr, input, 4 bits: number of rounds for the job; sampled only on acceptance.
REQ-007 SHALL have port state_in, input, ascon_state (320 bits): initial state; sampled only on acceptance.
REQ-008 SHALL have port out_valid, output, 1 bit: state_out holds a completed result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port state_out, output, ascon_state (320 bits): the internal state register.
REQ-011 SHALL have port busy, output, 1 bit: high in RUN.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse flagging a rejected job.

Function
REQ-013 SHALL contain one 320-bit state register, one round counter cnt (type round) and an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL build the datapath from UNROLL chained permutation instances; instance k SHALL use rnd = cnt + k.
REQ-015 SHALL define a legal nr as a value in 1..12 that is a multiple of UNROLL; 12 (pa) and 8 (pb) SHALL always be legal.
REQ-016 SHALL drive in_ready = 1 in IDLE, and in DONE when out_ready = 1; in_ready SHALL be 0 in all other cases.
REQ-017 SHALL define acceptance as in_valid & in_ready & legal nr; on acceptance SHALL load state_in into the state register, set cnt = 12 - nr and enter RUN.
REQ-018 SHALL, when in_valid & in_ready holds with an illegal nr, pulse err for one cycle, leave the state register unchanged and stay in IDLE, or go from DONE to IDLE if out_ready is high.
REQ-019 SHALL, each RUN cycle, load the chained permutation output into the state register and set cnt = cnt + UNROLL.
REQ-020 SHALL leave RUN for DONE on the cycle cnt + UNROLL = 12; that cycle's rounds are included.
REQ-021 SHALL hold the state register in DONE with out_valid = 1 until out_ready = 1.
REQ-022 SHALL, on out_ready = 1 in DONE, go to IDLE; if a legal job is also accepted that cycle, it SHALL go directly to RUN with the new job loaded (back-to-back).
REQ-023 SHALL spend exactly nr/UNROLL cycles in RUN; out_valid SHALL first rise nr/UNROLL + 1 cycles after the acceptance cycle.
REQ-024 SHALL ignore in_valid, nr and state_in while in RUN; no abort path exists.
REQ-025 SHALL drive state_out directly from the state register in all states; it is meaningful only when out_valid = 1.
REQ-026 SHALL generate busy and out_valid from the FSM state register only, with no combinational path from inputs.
REQ-027 SHALL keep the cnt arithmetic 4 bits wide; cnt SHALL never exceed 12 given a legal nr.

Reset
REQ-028 SHALL, on rst = 1 at a clock edge, force the FSM to IDLE, cnt to 0, the state register to 0 and err to 0, overriding every other event in that cycle.
REQ-029 SHALL apply REQ-028 when rst is asserted in RUN or DONE: the job is discarded and no out_valid follows.
REQ-030 SHALL give the following values while rst is high and in the first cycle after it is released: in_ready = 1, out_valid = 0, busy = 0, err = 0, state_out = 0.

Verification
REQ-031 SHALL cover this scenario: UNROLL=1, nr=12, state_in = all-zero -> busy for 12 cycles, out_valid on the 13th cycle after acceptance, state_out equal to the golden-model p^12(0), rnd sequence 0..11.
REQ-032 SHALL cover this scenario: UNROLL=1, nr=8 -> rnd sequence 4..11, out_valid 9 cycles after acceptance, state_out equal to the golden p^8.
REQ-033 SHALL cover this scenario: UNROLL=4, nr=12 -> 3 RUN cycles, out_valid 4 cycles after acceptance, result identical to UNROLL=1.
REQ-034 SHALL cover this scenario: out_ready held low for 5 cycles in DONE -> state_out stable and out_valid high throughout; out_ready=1 together with in_valid=1 -> new job enters RUN the next cycle with no IDLE cycle.
REQ-035 SHALL cover this scenario: nr=0, nr=13, and nr=6 with UNROLL=4 -> err pulses for one cycle, FSM stays IDLE, state_out unchanged.
REQ-036 SHALL cover this scenario: rst asserted on the 5th RUN cycle of an nr=12 job -> next cycle IDLE, state_out=0, in_ready=1, no out_valid.
